// File: rtl/bcd_mon_pkg.sv
// ---------------------------------------------------------------------------
// bcd_mon_pkg
// Shared types and helpers for the BCD counter monitor and its step
// classifier.
//   mon_state_e : monitor FSM states (EMPTY, SYNC, LOCK)
//   step_e      : classification of one sampled step (UP, DN, HOLD, JMP, BAD)
//   BCD_MAX     : largest legal BCD digit
//   bcd_succ / bcd_pred : mod-10 neighbours of a legal digit
// ---------------------------------------------------------------------------
package bcd_mon_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        SYNC,
        LOCK
    } mon_state_e;

    typedef enum logic [2:0] {
        UP,
        DN,
        HOLD,
        JMP,
        BAD
    } step_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_succ(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_pred(input logic [3:0] d);
        return (d == 4'd0) ? BCD_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/bcd_cnt_monitor_if.sv
// ---------------------------------------------------------------------------
// bcd_cnt_monitor_if
// Signal bundle between a BCD counter stream source and the monitor.
//   en, q_in        : sample strobe and sampled BCD digit (source -> monitor)
//   dir, locked     : recovered direction (0=up, 1=down) and lock level
//   carry, borrow   : wrap pulses (9->0 locked up, 0->9 locked down)
//   rev, jump, bad  : reversal, non-adjacent step, illegal digit pulses
//   last_q          : last legal digit sampled
// Modports: master = stream source / status consumer, slave = monitor.
// ---------------------------------------------------------------------------
interface bcd_cnt_monitor_if;

    logic       en;
    logic [3:0] q_in;
    logic       dir;
    logic       locked;
    logic       carry;
    logic       borrow;
    logic       rev;
    logic       jump;
    logic       bad;
    logic [3:0] last_q;

    modport master (
        output en, q_in,
        input  dir, locked, carry, borrow, rev, jump, bad, last_q
    );

    modport slave (
        input  en, q_in,
        output dir, locked, carry, borrow, rev, jump, bad, last_q
    );

endinterface

// File: rtl/bcd_step_classify.sv
// ---------------------------------------------------------------------------
// bcd_step_classify
// Combinational classification of one BCD step.
//   prev_i : previous legal digit (0..9)
//   q_i    : newly sampled value
//   step_o : BAD if q_i > 9, else UP / DN (mod-10 neighbour, wraps
//            included), HOLD (equal) or JMP (any other legal digit)
// ---------------------------------------------------------------------------
module bcd_step_classify
    import bcd_mon_pkg::*;
(
    input  logic [3:0] prev_i,
    input  logic [3:0] q_i,
    output step_e      step_o
);

    always_comb begin
        step_o = JMP;
        if (q_i > BCD_MAX) begin
            step_o = BAD;
        end else if (q_i == prev_i) begin
            step_o = HOLD;
        end else if (q_i == bcd_succ(prev_i)) begin
            step_o = UP;
        end else if (q_i == bcd_pred(prev_i)) begin
            step_o = DN;
        end
    end

endmodule

// File: rtl/bcd_cnt_monitor.sv
// ---------------------------------------------------------------------------
// bcd_cnt_monitor
// Observer for the output of a reversible BCD counter. Classifies each
// enabled sample against the previous digit, recovers the counting direction
// and lock status, and pulses on wrap, reversal, jump and illegal digits.
// All outputs are registered: the response to a sample appears one clk after
// the edge that sampled it.
//
// Ports:
//   clk : system clock, rising edge
//   res : synchronous reset, active-high
//   mon : bcd_cnt_monitor_if.slave (en, q_in in; dir, locked, carry, borrow,
//         rev, jump, bad, last_q out)
// Parameters:
//   LOCK_N : consecutive same-direction steps needed to lock (1..15)
// Build option:
//   BCD_HOLD_EN : when defined, a repeated digit is a legal stall; otherwise
//                 it is treated exactly like a jump.
// ---------------------------------------------------------------------------
module bcd_cnt_monitor
    import bcd_mon_pkg::*;
#(
    parameter int unsigned LOCK_N = 3
) (
    input  logic               clk,
    input  logic               res,
    bcd_cnt_monitor_if.slave   mon
);

`ifdef BCD_HOLD_EN
    localparam bit HOLD_LEGAL = 1'b1;
`else
    localparam bit HOLD_LEGAL = 1'b0;
`endif

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_N);

    // Saturating run-length increment.
    function automatic logic [3:0] run_inc(input logic [3:0] r);
        return (r == 4'hF) ? r : r + 4'd1;
    endfunction

    mon_state_e state_q, state_d;
    logic [3:0] run_q, run_d;
    logic       cand_q, cand_d;
    logic       dir_q, dir_d;
    logic       locked_q, locked_d;
    logic       carry_q, carry_d;
    logic       borrow_q, borrow_d;
    logic       rev_q, rev_d;
    logic       jump_q, jump_d;
    logic       bad_q, bad_d;
    logic [3:0] digit_q, digit_d;

    step_e      step_raw;
    step_e      step_eff;
    logic       step_dn;

    bcd_step_classify u_classify (
        .prev_i (digit_q),
        .q_i    (mon.q_in),
        .step_o (step_raw)
    );

    always_comb begin
        // A repeated digit folds into JMP unless stalls are legal.
        step_eff = (step_raw == HOLD && !HOLD_LEGAL) ? JMP : step_raw;
        step_dn  = (step_eff == DN);

        state_d  = state_q;
        run_d    = run_q;
        cand_d   = cand_q;
        dir_d    = dir_q;
        digit_d  = digit_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        rev_d    = 1'b0;
        jump_d   = 1'b0;
        bad_d    = 1'b0;

        if (mon.en) begin
            if (step_eff == BAD) begin
                bad_d   = 1'b1;
                state_d = EMPTY;
                run_d   = 4'd0;
            end else begin
                digit_d = mon.q_in;
                unique case (state_q)
                    EMPTY: begin
                        state_d = SYNC;
                        run_d   = 4'd0;
                    end
                    SYNC: begin
                        unique case (step_eff)
                            UP, DN: begin
                                if (run_q == 4'd0 || cand_q == step_dn) begin
                                    run_d = run_inc(run_q);
                                end else begin
                                    run_d = 4'd1;
                                end
                                cand_d = step_dn;
                                if (run_d >= LOCK_RUN) begin
                                    state_d = LOCK;
                                    dir_d   = step_dn;
                                end
                            end
                            HOLD: begin
                            end
                            default: begin
                                jump_d = 1'b1;
                                run_d  = 4'd0;
                            end
                        endcase
                    end
                    LOCK: begin
                        unique case (step_eff)
                            UP, DN: begin
                                // Wrap pulse follows the direction of this
                                // step, so a reversing step can also wrap.
                                dir_d    = step_dn;
                                rev_d    = (step_dn != dir_q);
                                carry_d  = !step_dn && (digit_q == BCD_MAX);
                                borrow_d = step_dn && (digit_q == 4'd0);
                            end
                            HOLD: begin
                            end
                            default: begin
                                jump_d  = 1'b1;
                                state_d = SYNC;
                                run_d   = 4'd0;
                            end
                        endcase
                    end
                    default: begin
                        state_d = EMPTY;
                        run_d   = 4'd0;
                    end
                endcase
            end
        end

        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q  <= EMPTY;
            run_q    <= 4'd0;
            cand_q   <= 1'b0;
            dir_q    <= 1'b0;
            locked_q <= 1'b0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            rev_q    <= 1'b0;
            jump_q   <= 1'b0;
            bad_q    <= 1'b0;
            digit_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            cand_q   <= cand_d;
            dir_q    <= dir_d;
            locked_q <= locked_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            rev_q    <= rev_d;
            jump_q   <= jump_d;
            bad_q    <= bad_d;
            digit_q  <= digit_d;
        end
    end

    assign mon.dir    = dir_q;
    assign mon.locked = locked_q;
    assign mon.carry  = carry_q;
    assign mon.borrow = borrow_q;
    assign mon.rev    = rev_q;
    assign mon.jump   = jump_q;
    assign mon.bad    = bad_q;
    assign mon.last_q = digit_q;

endmodule

// File: tb/tb_bcd_cnt_monitor.sv
// ---------------------------------------------------------------------------
// tb_bcd_cnt_monitor
// Directed vector table followed by randomized stimulus checked against a
// behavioural model of the monitor. Honours BCD_HOLD_EN like the design.
// ---------------------------------------------------------------------------
module tb_bcd_cnt_monitor;

`ifdef BCD_HOLD_EN
    localparam bit HL = 1'b1;
`else
    localparam bit HL = 1'b0;
`endif
    localparam int LOCK_N = 3;

    logic clk;
    logic res;

    bcd_cnt_monitor_if bus ();

    bcd_cnt_monitor #(.LOCK_N(LOCK_N)) dut (
        .clk (clk),
        .res (res),
        .mon (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-output word: {locked, dir, carry, borrow, rev, jump, bad, last_q}
    typedef struct {
        bit         r;
        bit         e;
        logic [3:0] q;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_have, m_locked, m_dir, m_cand;
    bit m_carry, m_borrow, m_rev, m_jump, m_bad;
    int m_run, m_last;

    task automatic add(input bit r, input bit e, input int q,
                       input bit l, input bit d, input bit c, input bit b,
                       input bit rv, input bit j, input bit x, input int last);
        vec_t v;
        v.r   = r;
        v.e   = e;
        v.q   = 4'(q);
        v.exp = {l, d, c, b, rv, j, x, 4'(last)};
        vecs.push_back(v);
    endtask

    function automatic logic [10:0] dut_word();
        return {bus.locked, bus.dir, bus.carry, bus.borrow, bus.rev,
                bus.jump, bus.bad, bus.last_q};
    endfunction

    function automatic logic [10:0] model_word();
        return {m_locked, m_dir, m_carry, m_borrow, m_rev, m_jump, m_bad,
                4'(m_last)};
    endfunction

    task automatic check(input string name, input logic [10:0] got,
                         input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got={L,D,C,B,R,J,X,last}=%b exp=%b", name, got, exp);
        end
    endtask

    // Model written from the step rules: step distance mod 10 decides class.
    task automatic model_update(input bit r, input bit e, input int q);
        int  d;
        bit  up, dn, hold;
        m_carry = 0; m_borrow = 0; m_rev = 0; m_jump = 0; m_bad = 0;
        if (r) begin
            m_have = 0; m_locked = 0; m_dir = 0; m_cand = 0;
            m_run = 0; m_last = 0;
        end else if (e) begin
            if (q > 9) begin
                m_bad = 1; m_have = 0; m_locked = 0; m_run = 0;
            end else begin
                d    = (q + 10 - m_last) % 10;
                up   = (d == 1);
                dn   = (d == 9);
                hold = (d == 0) && HL;
                if (!m_have) begin
                    m_have = 1;
                    m_run  = 0;
                end else if (hold) begin
                    // stall: nothing changes but the digit
                end else if (m_locked) begin
                    if (up || dn) begin
                        m_rev    = (dn != m_dir);
                        m_dir    = dn;
                        m_carry  = up && (q == 0);
                        m_borrow = dn && (q == 9);
                    end else begin
                        m_jump = 1; m_locked = 0; m_run = 0;
                    end
                end else begin
                    if (up || dn) begin
                        if (m_run == 0 || dn == m_cand)
                            m_run = (m_run < 15) ? m_run + 1 : 15;
                        else
                            m_run = 1;
                        m_cand = dn;
                        if (m_run >= LOCK_N) begin
                            m_locked = 1;
                            m_dir    = dn;
                        end
                    end else begin
                        m_jump = 1; m_run = 0;
                    end
                end
                m_last = q;
            end
        end
    endtask

    // Inputs change at negedge; outputs are sampled at the following negedge.
    task automatic apply(input bit r, input bit e, input int q);
        res      = r;
        bus.en   = e;
        bus.q_in = 4'(q);
        @(posedge clk);
        model_update(r, e, q);
        @(negedge clk);
    endtask

    initial begin
        int gen_val;
        bit gen_dn;
        int sel;
        bit r, e;
        int q;

        res = 1'b1; bus.en = 1'b0; bus.q_in = 4'd0;
        m_have = 0; m_locked = 0; m_dir = 0; m_cand = 0; m_run = 0; m_last = 0;
        m_carry = 0; m_borrow = 0; m_rev = 0; m_jump = 0; m_bad = 0;

        //   r e  q   L D C B R J X last
        // reset, then lock up on 5,6,7,8
        add(1,0, 0,  0,0,0,0,0,0,0,0);
        add(1,0, 0,  0,0,0,0,0,0,0,0);
        add(0,1, 5,  0,0,0,0,0,0,0,5);
        add(0,1, 6,  0,0,0,0,0,0,0,6);
        add(0,1, 7,  0,0,0,0,0,0,0,7);
        add(0,1, 8,  1,0,0,0,0,0,0,8);
        // carry on 9->0, single cycle
        add(0,1, 9,  1,0,0,0,0,0,0,9);
        add(0,1, 0,  1,0,1,0,0,0,0,0);
        add(0,1, 1,  1,0,0,0,0,0,0,1);
        // up to 4, reverse down, borrow on 0->9
        add(0,1, 2,  1,0,0,0,0,0,0,2);
        add(0,1, 3,  1,0,0,0,0,0,0,3);
        add(0,1, 4,  1,0,0,0,0,0,0,4);
        add(0,1, 3,  1,1,0,0,1,0,0,3);
        add(0,1, 2,  1,1,0,0,0,0,0,2);
        add(0,1, 1,  1,1,0,0,0,0,0,1);
        add(0,1, 0,  1,1,0,0,0,0,0,0);
        add(0,1, 9,  1,1,0,1,0,0,0,9);
        add(0,1, 8,  1,1,0,0,0,0,0,8);
        // down to 3, load 7, relock up without carry on 9->0
        add(0,1, 7,  1,1,0,0,0,0,0,7);
        add(0,1, 6,  1,1,0,0,0,0,0,6);
        add(0,1, 5,  1,1,0,0,0,0,0,5);
        add(0,1, 4,  1,1,0,0,0,0,0,4);
        add(0,1, 3,  1,1,0,0,0,0,0,3);
        add(0,1, 7,  0,1,0,0,0,1,0,7);
        add(0,1, 8,  0,1,0,0,0,0,0,8);
        add(0,1, 9,  0,1,0,0,0,0,0,9);
        add(0,1, 0,  1,0,0,0,0,0,0,0);
        // illegal digit while locked, resync, reset mid-sequence
        add(0,1, 1,  1,0,0,0,0,0,0,1);
        add(0,1,12,  0,0,0,0,0,0,1,1);
        add(0,1, 4,  0,0,0,0,0,0,0,4);
        add(0,1, 5,  0,0,0,0,0,0,0,5);
        add(1,1, 6,  0,0,0,0,0,0,0,0);
        add(0,0, 6,  0,0,0,0,0,0,0,0);
        // lock at 4, then en=0 for 3 clk with wrap/illegal values presented
        add(0,1, 1,  0,0,0,0,0,0,0,1);
        add(0,1, 2,  0,0,0,0,0,0,0,2);
        add(0,1, 3,  0,0,0,0,0,0,0,3);
        add(0,1, 4,  1,0,0,0,0,0,0,4);
        add(0,0, 9,  1,0,0,0,0,0,0,4);
        add(0,0, 0,  1,0,0,0,0,0,0,4);
        add(0,0,12,  1,0,0,0,0,0,0,4);
        add(0,1, 5,  1,0,0,0,0,0,0,5);
        // repeated digit: legal stall or jump depending on build
        add(0,1, 5,  HL,0,0,0,0,!HL,0,5);
        add(0,1, 6,  HL,0,0,0,0,0,0,6);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].e, int'(vecs[i].q));
            check($sformatf("vec[%0d]", i), dut_word(), vecs[i].exp);
        end

        // Randomized counter-like stream with occasional disturbances.
        gen_val = 6;
        gen_dn  = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 99);
            r = 1'b0;
            e = 1'b1;
            q = gen_val;
            if (sel < 2) begin
                r = 1'b1;
            end else if (sel < 9) begin
                e = 1'b0;
                q = $urandom_range(0, 15);
            end else if (sel < 12) begin
                q = $urandom_range(10, 15);
            end else if (sel < 16) begin
                gen_val = $urandom_range(0, 9);
                q = gen_val;
            end else if (sel < 21) begin
                q = gen_val;
            end else begin
                if (sel < 26) gen_dn = !gen_dn;
                gen_val = gen_dn ? (gen_val + 9) % 10 : (gen_val + 1) % 10;
                q = gen_val;
            end
            apply(r, e, q);
            check($sformatf("rand[%0d] r=%0b e=%0b q=%0d", n, r, e, q),
                  dut_word(), model_word());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_cnt_monitor.md
Name: bcd_cnt_monitor

Overview:
Observer for the output stream of the reversible BCD counter. It samples the 4-bit BCD value on each enabled clock and classifies each step as up, down, hold, jump or invalid. From consistent steps it recovers the counting direction and lock status, and pulses on wrap, reversal, parallel-load jump and invalid digits. It sits beside the counter as a checker and status source for display and control logic.

Parameters:
LOCK_N, 3, consecutive same-direction steps required to declare lock (1..15)

Ports:
clk  input  1  system clock, rising edge
res  input  1  synchronous reset, active-high
en  input  1  sample strobe; q_in is sampled only when en=1
q_in  input  4  BCD value from the counter
dir  output  1  recovered direction: 0=up, 1=down (matches counter revers=1 counting down)
locked  output  1  level, direction is established
carry  output  1  1-cycle pulse, 9->0 while locked up
borrow  output  1  1-cycle pulse, 0->9 while locked down
rev  output  1  1-cycle pulse, direction reversal while locked
jump  output  1  1-cycle pulse, non-adjacent valid step (parallel load)
bad  output  1  1-cycle pulse, q_in > 9 sampled
last_q  output  4  last valid sampled digit

Behaviour:
- Reset (res=1 at a clk edge): state EMPTY; run=0; dir, locked, carry, borrow, rev, jump, bad = 0; last_q=0. Reset overrides en and any mid-lock operation.
- All outputs are registered. The response to a sample appears one clk after the edge that samples it.
- en=0: state, run, dir and last_q hold; all pulse outputs are 0.
- Step class of a valid q_in vs prev (last_q):
  - UP: q_in == (prev+1) mod 10, including 9->0.
  - DN: q_in == (prev+9) mod 10, including 0->9.
  - HOLD: q_in == prev.
  - JUMP: any other valid digit.
- BAD (q_in > 9), any state: bad=1; go to EMPTY; locked=0; run=0; last_q unchanged.
- last_q updates on every valid sample.
- EMPTY, valid sample: store it; go to SYNC; run=0.
- SYNC:
  - UP/DN, same as the candidate direction or run==0: cand=class; run+1.
  - UP/DN, otherwise: cand=class; run=1.
  - When run reaches LOCK_N: go to LOCK; locked=1; dir=cand.
  - JUMP: jump=1; run=0.
- LOCK:
  - Step in dir: stay. Pulse carry on 9->0 when dir=0, or borrow on 0->9 when dir=1.
  - Opposite step: dir toggles; rev=1; stay locked. The wrap pulse for the new direction also fires if this step wraps.
  - JUMP: jump=1; go to SYNC; locked=0; run=0.
- HOLD (SYNC/LOCK), behaviour depends on BCD_HOLD_EN (see Optional Feature).
- run is saturating 4-bit; wraps never reach 16.

Optional Feature:
BCD_HOLD_EN
- Defined: HOLD is legal (counter stalled). State, run and dir are unchanged; no pulse.
- Undefined: HOLD is treated as JUMP. jump=1; LOCK->SYNC; run=0.

Decomposition:
- Package bcd_mon_pkg:
  - State enum {EMPTY, SYNC, LOCK}.
  - Step enum {UP, DN, HOLD, JMP, BAD}.
  - Constant BCD_MAX=9.
- Sub-module bcd_step_classify: combinational; prev, q_in -> step class. Reused by counter checkers.
- The FSM and registers stay in bcd_cnt_monitor.

Test Plan:
1. res=1 for 2 clk, then en=1 with q_in 5,6,7,8 -> locked=1, dir=0, one clk after 8 is sampled; no pulses.
2. Locked up, feed 8,9,0 -> carry=1 for exactly one clk after 0 is sampled; last_q=0.
3. Locked up at 4, feed 3,2,1,0,9 -> rev pulse after 3 with dir=1; borrow pulse after 9; locked stays 1.
4. Locked, feed 3 then 7 (load) -> jump pulse, locked=0; then 8,9,0 -> relock dir=0 after 0, no carry on that 9->0 (not yet locked).
5. Feed q_in=12 while locked -> bad pulse, locked=0, last_q unchanged; next 4 enters SYNC; assert res mid-sequence -> all outputs 0 next clk.
6. Locked up at 5, feed 5 -> with BCD_HOLD_EN: no pulse, still locked; without: jump=1, locked=0. Toggle en=0 for 3 clk mid-lock -> no change.
